// File: rtl/qupls4_uop_queue.sv
// Micro-op queue ahead of the Qupls4 decoder: two-wide compacting enqueue,
// single pop per cycle, flush and sticky overflow; empty head reads as zero.
module qupls4_uop_queue #(
   parameter int DEPTH = 8,
   parameter int UOPW  = 48,
   parameter int RAWW  = 336,
   parameter int IPW   = 32,
   parameter int OMW   = 2
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [1:0]               enq_v,
   input  logic [UOPW-1:0]          enq_uop0,
   input  logic [UOPW-1:0]          enq_uop1,
   input  logic [RAWW-1:0]          enq_raw0,
   input  logic [RAWW-1:0]          enq_raw1,
   input  logic [IPW-1:0]           enq_ip0,
   input  logic [IPW-1:0]           enq_ip1,
   input  logic [OMW-1:0]           enq_om,
   input  logic [5:0]               enq_ipl,
   output logic                     enq_rdy,
   input  logic                     deq_en,
   output logic                     out_v,
   output logic [UOPW-1:0]          out_instr,
   output logic [RAWW-1:0]          out_instr_raw,
   output logic [IPW-1:0]           out_ip,
   output logic [OMW-1:0]           out_om,
   output logic [5:0]               out_ipl,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [UOPW-1:0] uop;
      logic [RAWW-1:0] raw;
      logic [IPW-1:0]  ip;
      logic [OMW-1:0]  om;
      logic [5:0]      ipl;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          e0, e1, head;
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic            acc, deq;
   logic [1:0]      n_enq;

   assign e0 = '{uop: enq_uop0, raw: enq_raw0, ip: enq_ip0, om: enq_om, ipl: enq_ipl};
   assign e1 = '{uop: enq_uop1, raw: enq_raw1, ip: enq_ip1, om: enq_om, ipl: enq_ipl};

   // Room check uses registered count only so a pop never widens the window.
   assign enq_rdy = (count <= CW'(DEPTH - 2));
   assign out_v   = (count != '0);
   assign acc     = enq_rdy & (|enq_v) & ~flush;
   assign deq     = deq_en & out_v & ~flush;
   assign n_enq   = acc ? (2'(enq_v[0]) + 2'(enq_v[1])) : 2'd0;

   assign head          = out_v ? mem[rd_ptr] : '0;
   assign out_instr     = head.uop;
   assign out_instr_raw = head.raw;
   assign out_ip        = head.ip;
   assign out_om        = head.om;
   assign out_ipl       = head.ipl;

   // Slot 1 lands at wr_ptr when slot 0 is idle (compaction).
   always_ff @(posedge clk) begin
      if (acc) begin
         if (enq_v[0])
            mem[wr_ptr] <= e0;
         if (enq_v == 2'b11)
            mem[wr_ptr + AW'(1)] <= e1;
         else if (enq_v == 2'b10)
            mem[wr_ptr] <= e1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if ((|enq_v) && !enq_rdy)
            ovf <= 1'b1;
         wr_ptr <= wr_ptr + AW'(n_enq);
         rd_ptr <= rd_ptr + AW'(deq);
         count  <= count + CW'(n_enq) - CW'(deq);
      end
   end
endmodule

// File: tb/tb_qupls4_uop_queue.sv
// Directed bench for the micro-op queue: vector table plus hand-built
// sequences for pointer wrap, flush collision and asynchronous reset.
module tb_qupls4_uop_queue;
   localparam int DEPTH = 8;
   localparam int UOPW  = 48;
   localparam int RAWW  = 336;
   localparam int IPW   = 32;
   localparam int OMW   = 2;
   localparam logic [OMW-1:0] OM  = 2'b10;
   localparam logic [5:0]     IPL = 6'h2A;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              flush = 1'b0;
   logic [1:0]        enq_v = '0;
   logic [UOPW-1:0]   enq_uop0 = '0, enq_uop1 = '0;
   logic [RAWW-1:0]   enq_raw0 = '0, enq_raw1 = '0;
   logic [IPW-1:0]    enq_ip0 = '0, enq_ip1 = '0;
   logic [OMW-1:0]    enq_om = '0;
   logic [5:0]        enq_ipl = '0;
   logic              enq_rdy;
   logic              deq_en = 1'b0;
   logic              out_v;
   logic [UOPW-1:0]   out_instr;
   logic [RAWW-1:0]   out_instr_raw;
   logic [IPW-1:0]    out_ip;
   logic [OMW-1:0]    out_om;
   logic [5:0]        out_ipl;
   logic [3:0]        count;
   logic              ovf;

   int n_chk  = 0;
   int n_fail = 0;

   qupls4_uop_queue #(.DEPTH(DEPTH), .UOPW(UOPW), .RAWW(RAWW), .IPW(IPW), .OMW(OMW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .enq_v(enq_v),
      .enq_uop0(enq_uop0), .enq_uop1(enq_uop1),
      .enq_raw0(enq_raw0), .enq_raw1(enq_raw1),
      .enq_ip0(enq_ip0), .enq_ip1(enq_ip1),
      .enq_om(enq_om), .enq_ipl(enq_ipl), .enq_rdy(enq_rdy),
      .deq_en(deq_en), .out_v(out_v), .out_instr(out_instr),
      .out_instr_raw(out_instr_raw), .out_ip(out_ip), .out_om(out_om),
      .out_ipl(out_ipl), .count(count), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [UOPW-1:0] uop_of(input logic [IPW-1:0] ip);
      return {16'hA5A5, ip};
   endfunction

   function automatic logic [RAWW-1:0] raw_of(input logic [IPW-1:0] ip);
      return {ip, 240'h0, ~ip, ip};
   endfunction

   task automatic chk(input string name, input logic [RAWW-1:0] act, input logic [RAWW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: drive, clock, then sample 1 time unit after the edge.
   task automatic step(input logic [1:0] v, input logic d, input logic f,
                       input logic [IPW-1:0] ip0, input logic [IPW-1:0] ip1);
      enq_v = v; deq_en = d; flush = f;
      enq_ip0 = ip0; enq_ip1 = ip1;
      enq_uop0 = uop_of(ip0); enq_uop1 = uop_of(ip1);
      enq_raw0 = raw_of(ip0); enq_raw1 = raw_of(ip1);
      enq_om = OM; enq_ipl = IPL;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic v, input logic [IPW-1:0] ip);
      chk({tag, ".out_v"},  RAWW'(out_v), RAWW'(v));
      chk({tag, ".out_ip"}, RAWW'(out_ip), v ? RAWW'(ip) : '0);
      chk({tag, ".instr"},  RAWW'(out_instr), v ? RAWW'(uop_of(ip)) : '0);
      chk({tag, ".raw"},    out_instr_raw, v ? raw_of(ip) : '0);
      chk({tag, ".om_ipl"}, RAWW'({out_om, out_ipl}), v ? RAWW'({OM, IPL}) : '0);
   endtask

   typedef struct {
      logic [1:0]     v;
      logic           deq;
      logic           fl;
      logic [IPW-1:0] ip0, ip1;
      logic [3:0]     cnt;
      logic           hv;
      logic [IPW-1:0] hip;
      logic           ovf;
      logic           rdy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [1:0] v, input logic deq, input logic fl,
                      input logic [IPW-1:0] ip0, input logic [IPW-1:0] ip1,
                      input logic [3:0] cnt, input logic hv, input logic [IPW-1:0] hip,
                      input logic ov, input logic rdy);
      vec_t r;
      r.v = v; r.deq = deq; r.fl = fl; r.ip0 = ip0; r.ip1 = ip1;
      r.cnt = cnt; r.hv = hv; r.hip = hip; r.ovf = ov; r.rdy = rdy;
      tbl.push_back(r);
   endtask

   initial begin
      //   v      deq   fl    ip0      ip1      cnt hv  head     ovf rdy
      add(2'b11, 1'b0, 1'b0, 32'h100, 32'h104, 2, 1, 32'h100, 0, 1);
      add(2'b11, 1'b0, 1'b0, 32'h108, 32'h10C, 4, 1, 32'h100, 0, 1);
      add(2'b11, 1'b0, 1'b0, 32'h110, 32'h114, 6, 1, 32'h100, 0, 1);
      add(2'b11, 1'b0, 1'b0, 32'h118, 32'h11C, 8, 1, 32'h100, 0, 0);
      add(2'b01, 1'b0, 1'b0, 32'h200, 32'h0,   8, 1, 32'h100, 1, 0);
      add(2'b00, 1'b1, 1'b0, 32'h0,   32'h0,   7, 1, 32'h104, 1, 0);
      add(2'b00, 1'b1, 1'b0, 32'h0,   32'h0,   6, 1, 32'h108, 1, 1);
      add(2'b00, 1'b1, 1'b0, 32'h0,   32'h0,   5, 1, 32'h10C, 1, 1);
      add(2'b00, 1'b1, 1'b0, 32'h0,   32'h0,   4, 1, 32'h110, 1, 1);
      add(2'b00, 1'b1, 1'b0, 32'h0,   32'h0,   3, 1, 32'h114, 1, 1);
      add(2'b00, 1'b1, 1'b0, 32'h0,   32'h0,   2, 1, 32'h118, 1, 1);
      add(2'b00, 1'b1, 1'b0, 32'h0,   32'h0,   1, 1, 32'h11C, 1, 1);
      add(2'b00, 1'b1, 1'b0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 1);
      add(2'b00, 1'b1, 1'b0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 1);
      add(2'b00, 1'b0, 1'b1, 32'h0,   32'h0,   0, 0, 32'h0,   0, 1);
      add(2'b11, 1'b0, 1'b0, 32'h300, 32'h304, 2, 1, 32'h300, 0, 1);
      add(2'b11, 1'b0, 1'b0, 32'h308, 32'h30C, 4, 1, 32'h300, 0, 1);
      add(2'b11, 1'b0, 1'b0, 32'h310, 32'h314, 6, 1, 32'h300, 0, 1);
      add(2'b11, 1'b1, 1'b0, 32'h318, 32'h31C, 7, 1, 32'h304, 0, 0);
      add(2'b01, 1'b0, 1'b0, 32'h400, 32'h0,   7, 1, 32'h304, 1, 0);
      add(2'b00, 1'b0, 1'b1, 32'h0,   32'h0,   0, 0, 32'h0,   0, 1);

      // Reset held with random inputs.
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         enq_v = 2'($urandom); deq_en = 1'($urandom); flush = 1'($urandom);
         enq_ip0 = $urandom; enq_ip1 = $urandom;
         @(posedge clk);
         #1;
      end
      chk_head("reset", 1'b0, '0);
      chk("reset.count",   RAWW'(count), '0);
      chk("reset.enq_rdy", RAWW'(enq_rdy), RAWW'(1));
      chk("reset.ovf",     RAWW'(ovf), '0);
      enq_v = '0; deq_en = 1'b0; flush = 1'b0;
      rst = 1'b1;

      foreach (tbl[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         step(tbl[i].v, tbl[i].deq, tbl[i].fl, tbl[i].ip0, tbl[i].ip1);
         chk({tag, ".count"},   RAWW'(count),   RAWW'(tbl[i].cnt));
         chk({tag, ".ovf"},     RAWW'(ovf),     RAWW'(tbl[i].ovf));
         chk({tag, ".enq_rdy"}, RAWW'(enq_rdy), RAWW'(tbl[i].rdy));
         chk_head(tag, tbl[i].hv, tbl[i].hip);
      end

      // Slot-1-only enqueue with continuous pop, crossing the pointer wrap.
      for (int i = 0; i < 11; i++) begin
         step(2'b10, 1'b1, 1'b0, 32'hDEAD, 32'h500 + 32'(4 * i));
         chk($sformatf("wrap%0d.count", i), RAWW'(count), RAWW'(1));
         chk($sformatf("wrap%0d.ip", i), RAWW'(out_ip), RAWW'(32'h500 + 32'(4 * i)));
      end
      step(2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
      chk("wrap.drain_count", RAWW'(count), '0);
      chk("wrap.drain_v", RAWW'(out_v), '0);

      // Flush colliding with enqueue and dequeue.
      step(2'b11, 1'b0, 1'b0, 32'h600, 32'h604);
      step(2'b11, 1'b0, 1'b0, 32'h608, 32'h60C);
      chk("coll.pre_count", RAWW'(count), RAWW'(4));
      chk_head("coll.pre", 1'b1, 32'h600);
      step(2'b11, 1'b1, 1'b1, 32'h610, 32'h614);
      chk("coll.count", RAWW'(count), '0);
      chk("coll.enq_rdy", RAWW'(enq_rdy), RAWW'(1));
      chk_head("coll", 1'b0, '0);
      step(2'b11, 1'b0, 1'b0, 32'h700, 32'h704);
      chk("recov.count", RAWW'(count), RAWW'(2));
      chk_head("recov", 1'b1, 32'h700);

      // Asynchronous reset between clock edges.
      enq_v = 2'b00;
      #3;
      rst = 1'b0;
      #1;
      chk("areset.count", RAWW'(count), '0);
      chk("areset.enq_rdy", RAWW'(enq_rdy), RAWW'(1));
      chk_head("areset", 1'b0, '0);
      @(negedge clk);
      rst = 1'b1;
      step(2'b11, 1'b0, 1'b0, 32'h800, 32'h804);
      chk("post.count", RAWW'(count), RAWW'(2));
      chk_head("post", 1'b1, 32'h800);
      step(2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
      chk_head("post.pop", 1'b1, 32'h804);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
